// File: rtl/cache_controller_pkg.sv
// Shared types and default geometry for the direct-mapped write-back data cache.
// Tag entries are packed as {valid, dirty, tag}.
package cache_pkg;

   localparam int CC_ADDR_W   = 32;
   localparam int CC_OFFSET_W = 2;
   localparam int CC_IDX_W    = 5;
   localparam int CC_DATA_W   = 32;

   localparam int TAG_W     = CC_ADDR_W - CC_IDX_W - CC_OFFSET_W;
   localparam int TAG_MEM_W = TAG_W + 2;
   localparam int VALID_POS = TAG_MEM_W - 1;
   localparam int DIRTY_POS = TAG_MEM_W - 2;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_COMPARE,
      ST_WRITEBACK,
      ST_ALLOCATE
   } state_e;

   function automatic logic [TAG_W-1:0] addr_tag(input logic [CC_ADDR_W-1:0] addr);
      return addr[CC_ADDR_W-1 -: TAG_W];
   endfunction

   function automatic logic [CC_IDX_W-1:0] addr_idx(input logic [CC_ADDR_W-1:0] addr);
      return addr[CC_OFFSET_W +: CC_IDX_W];
   endfunction

endpackage

// File: rtl/cache_controller_if.sv
// Bundle of CPU, tag/data array and memory bus signals around the cache controller.
// master = controller side, slave = core/arrays/bus side.
interface cache_controller_if #(
   parameter int ADDR_W    = cache_pkg::CC_ADDR_W,
   parameter int IDX_W     = cache_pkg::CC_IDX_W,
   parameter int DATA_W    = cache_pkg::CC_DATA_W,
   parameter int TAG_MEM_W = cache_pkg::TAG_MEM_W
) ();

   logic                 cpu_req;
   logic                 cpu_we;
   logic [ADDR_W-1:0]    cpu_addr;
   logic [DATA_W-1:0]    cpu_wdata;
   logic [DATA_W-1:0]    cpu_rdata;
   logic                 cpu_ready;

   logic                 tag_we;
   logic [IDX_W-1:0]     tag_idx;
   logic [TAG_MEM_W-1:0] tag_wentry;
   logic [TAG_MEM_W-1:0] tag_rentry;
   logic                 data_we;
   logic [DATA_W-1:0]    data_wdata;
   logic [DATA_W-1:0]    data_rdata;

   logic                 mem_req;
   logic                 mem_we;
   logic [ADDR_W-1:0]    mem_addr;
   logic [DATA_W-1:0]    mem_wdata;
   logic [DATA_W-1:0]    mem_rdata;
   logic                 mem_ack;

   modport master (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_ready,
      output tag_we, tag_idx, tag_wentry, data_we, data_wdata,
      input  tag_rentry, data_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_ready,
      input  tag_we, tag_idx, tag_wentry, data_we, data_wdata,
      output tag_rentry, data_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );

endinterface

// File: rtl/cache_controller.sv
// Sequencer for a direct-mapped, write-back, one-word-per-line data cache:
// post-reset invalidate sweep, hit/miss resolution, dirty write-back and line fill.
module cache_controller #(
   parameter int ADDR_W   = cache_pkg::CC_ADDR_W,
   parameter int OFFSET_W = cache_pkg::CC_OFFSET_W,
   parameter int IDX_W    = cache_pkg::CC_IDX_W,
   parameter int DATA_W   = cache_pkg::CC_DATA_W
) (
   input  logic              iCLK,
   input  logic              iRST_N,
   cache_controller_if.master bus
);
   import cache_pkg::*;

   localparam int TAG_BITS = ADDR_W - IDX_W - OFFSET_W;
   localparam int ENTRY_W  = TAG_BITS + 2;
   localparam int V_BIT    = ENTRY_W - 1;
   localparam int D_BIT    = ENTRY_W - 2;

   state_e                state_q, state_d;
   logic [IDX_W-1:0]      init_cnt_q, init_cnt_d;
   logic                  req_we_q, req_we_d;
   logic [TAG_BITS-1:0]   req_tag_q, req_tag_d;
   logic [IDX_W-1:0]      req_idx_q, req_idx_d;
   logic [DATA_W-1:0]     req_wdata_q, req_wdata_d;
   logic [DATA_W-1:0]     rdata_q, rdata_d;
   logic                  mem_req_q, mem_req_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;

   logic                  tag_we;
   logic [IDX_W-1:0]      tag_idx;
   logic [ENTRY_W-1:0]    tag_wentry;
   logic                  data_we;
   logic [DATA_W-1:0]     data_wdata;
   logic                  cpu_ready;
   logic [DATA_W-1:0]     cpu_rdata;

   logic                  entry_valid;
   logic                  entry_dirty;
   logic [TAG_BITS-1:0]   entry_tag;
   logic                  hit;
   logic                  unused_offset;

   assign entry_valid   = bus.tag_rentry[V_BIT];
   assign entry_dirty   = bus.tag_rentry[D_BIT];
   assign entry_tag     = bus.tag_rentry[TAG_BITS-1:0];
   assign hit           = entry_valid && (entry_tag == req_tag_q);
   assign unused_offset = ^bus.cpu_addr[OFFSET_W-1:0];

   always_comb begin
      state_d     = state_q;
      init_cnt_d  = init_cnt_q;
      req_we_d    = req_we_q;
      req_tag_d   = req_tag_q;
      req_idx_d   = req_idx_q;
      req_wdata_d = req_wdata_q;
      rdata_d     = rdata_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      tag_we      = 1'b0;
      tag_idx     = req_idx_q;
      tag_wentry  = '0;
      data_we     = 1'b0;
      data_wdata  = req_wdata_q;
      cpu_ready   = 1'b0;
      cpu_rdata   = rdata_q;

      case (state_q)
         ST_INIT: begin
            tag_we     = 1'b1;
            tag_idx    = init_cnt_q;
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == {IDX_W{1'b1}}) begin
               state_d = ST_IDLE;
            end
         end

         ST_IDLE: begin
            if (bus.cpu_req) begin
               req_we_d    = bus.cpu_we;
               req_tag_d   = bus.cpu_addr[ADDR_W-1 -: TAG_BITS];
               req_idx_d   = bus.cpu_addr[OFFSET_W +: IDX_W];
               req_wdata_d = bus.cpu_wdata;
               state_d     = ST_COMPARE;
            end
         end

         ST_COMPARE: begin
            if (hit) begin
               cpu_ready = 1'b1;
               state_d   = ST_IDLE;
               if (req_we_q) begin
                  data_we    = 1'b1;
                  tag_we     = 1'b1;
                  tag_wentry = {1'b1, 1'b1, req_tag_q};
               end else begin
                  cpu_rdata = bus.data_rdata;
                  rdata_d   = bus.data_rdata;
               end
            end else if (entry_valid && entry_dirty) begin
               // Victim word is captured here so the bus sees it stable for the whole write-back.
               state_d     = ST_WRITEBACK;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = {entry_tag, req_idx_q, {OFFSET_W{1'b0}}};
               mem_wdata_d = bus.data_rdata;
            end else begin
               state_d    = ST_ALLOCATE;
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = {req_tag_q, req_idx_q, {OFFSET_W{1'b0}}};
            end
         end

         ST_WRITEBACK: begin
            if (bus.mem_ack) begin
               state_d    = ST_ALLOCATE;
               mem_we_d   = 1'b0;
               mem_addr_d = {req_tag_q, req_idx_q, {OFFSET_W{1'b0}}};
            end
         end

         ST_ALLOCATE: begin
            // Fill installs a clean line; a store then hits on re-compare and sets dirty.
            if (bus.mem_ack) begin
               data_we    = 1'b1;
               data_wdata = bus.mem_rdata;
               tag_we     = 1'b1;
               tag_wentry = {1'b1, 1'b0, req_tag_q};
               mem_req_d  = 1'b0;
               state_d    = ST_COMPARE;
            end
         end

         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q     <= ST_INIT;
         init_cnt_q  <= '0;
         req_we_q    <= 1'b0;
         req_tag_q   <= '0;
         req_idx_q   <= '0;
         req_wdata_q <= '0;
         rdata_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         req_we_q    <= req_we_d;
         req_tag_q   <= req_tag_d;
         req_idx_q   <= req_idx_d;
         req_wdata_q <= req_wdata_d;
         rdata_q     <= rdata_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign bus.tag_we     = tag_we;
   assign bus.tag_idx    = tag_idx;
   assign bus.tag_wentry = tag_wentry;
   assign bus.data_we    = data_we;
   assign bus.data_wdata = data_wdata;
   assign bus.cpu_ready  = cpu_ready;
   assign bus.cpu_rdata  = cpu_rdata;
   assign bus.mem_req    = mem_req_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;

endmodule
